neighbor_fifo_dispatcher: RTL

- Sits directly downstream of the neighbour sync FIFO. Pops Neighbor_info2Neighbor_FIFO entries and routes each one to one of NUM_BANKS neighbour-memory banks, selected by the entry's bank_id field.
- Absorbs the FIFO's registered read: data arrives 1 cycle after the pop, and rdata reads 0 when no pop occurred.
- Per-bank valid/ready handshake with hold-until-accepted; a dispatched-entry counter and an idle flag go to the controller.

---
 rtl/neighbor_fifo_dispatcher_pkg.sv | 23 ++
 rtl/neighbor_bank_onehot_dec.sv | 15 +
 rtl/neighbor_fifo_dispatcher.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/neighbor_fifo_dispatcher_pkg.sv
// rtl/neighbor_fifo_dispatcher_pkg.sv - shared types for the neighbour FIFO dispatcher
`ifndef Num_Banks_Neighbor
`define Num_Banks_Neighbor 4
`endif

package neighbor_fifo_dispatcher_pkg;

    localparam int NUM_BANKS_NEIGHBOR = `Num_Banks_Neighbor;
    localparam int BANK_ID_W          = $clog2(`Num_Banks_Neighbor);

    typedef struct packed {
        logic [15:0]          node_id;
        logic [7:0]           weight;
        logic [BANK_ID_W-1:0] bank_id;
    } Neighbor_info2Neighbor_FIFO;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE
    } dispatch_state_t;

endpackage

// File: rtl/neighbor_bank_onehot_dec.sv
// rtl/neighbor_bank_onehot_dec.sv - bank_id plus valid to one-hot bank request vector
module neighbor_bank_onehot_dec #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic [BANK_W-1:0]    bank_id,
    input  logic                 valid,
    output logic [NUM_BANKS-1:0] onehot
);

    localparam logic [NUM_BANKS-1:0] ONE = {{(NUM_BANKS-1){1'b0}}, 1'b1};

    assign onehot = valid ? (ONE << bank_id) : '0;

endmodule

// File: rtl/neighbor_fifo_dispatcher.sv
// rtl/neighbor_fifo_dispatcher.sv - pops neighbour FIFO entries and routes them to banks by bank_id
// Optional 2-entry skid buffer with back-to-back pops: NEIGHBOR_DISPATCH_PREFETCH_EN
module neighbor_fifo_dispatcher
    import neighbor_fifo_dispatcher_pkg::*;
#(
    parameter int NUM_BANKS = NUM_BANKS_NEIGHBOR,
    parameter int BANK_W    = $clog2(NUM_BANKS),
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_rempty,
    input  Neighbor_info2Neighbor_FIFO fifo_rdata,
    output logic                       fifo_rinc,
    input  logic [NUM_BANKS-1:0]       bank_ready,
    output logic [NUM_BANKS-1:0]       bank_req_valid,
    output Neighbor_info2Neighbor_FIFO bank_req_data,
    input  logic                       cnt_clear,
    output logic [CNT_W-1:0]           dispatch_cnt,
    output logic                       idle
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    Neighbor_info2Neighbor_FIFO hold_q;
    logic                       issue_valid;
    logic                       hs;

`ifdef NEIGHBOR_DISPATCH_PREFETCH_EN
    Neighbor_info2Neighbor_FIFO next_q, hold_n, next_n;
    logic                       hold_valid, next_valid, pending;
    logic                       hold_valid_n, next_valid_n;
    logic [1:0]                 occ;

    assign hs          = hold_valid & bank_ready[hold_q.bank_id];
    assign occ         = {1'b0, hold_valid} + {1'b0, next_valid} + {1'b0, pending} - {1'b0, hs};
    assign fifo_rinc   = !fifo_rempty && (occ < 2'd2);
    assign issue_valid = hold_valid;
    assign idle        = !hold_valid && !next_valid && !pending && fifo_rempty;

    // Shift next into hold on acceptance first so returning data always lands behind older entries.
    always_comb begin
        hold_valid_n = hold_valid;
        hold_n       = hold_q;
        next_valid_n = next_valid;
        next_n       = next_q;
        if (hs) begin
            hold_valid_n = next_valid;
            hold_n       = next_q;
            next_valid_n = 1'b0;
            next_n       = '0;
        end
        if (pending) begin
            if (!hold_valid_n) begin
                hold_valid_n = 1'b1;
                hold_n       = fifo_rdata;
            end else begin
                next_valid_n = 1'b1;
                next_n       = fifo_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_q     <= '0;
            next_valid <= 1'b0;
            next_q     <= '0;
            pending    <= 1'b0;
        end else begin
            hold_valid <= hold_valid_n;
            hold_q     <= hold_n;
            next_valid <= next_valid_n;
            next_q     <= next_n;
            pending    <= fifo_rinc;
        end
    end
`else
    dispatch_state_t state, state_n;

    assign issue_valid = (state == ISSUE);
    assign hs          = issue_valid & bank_ready[hold_q.bank_id];
    assign idle        = (state == IDLE) && fifo_rempty;

    always_comb begin
        state_n   = state;
        fifo_rinc = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_rempty) begin
                    fifo_rinc = 1'b1;
                    state_n   = FETCH;
                end
            end
            FETCH: state_n = ISSUE;
            ISSUE: begin
                if (hs) begin
                    if (!fifo_rempty) begin
                        fifo_rinc = 1'b1;
                        state_n   = FETCH;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            hold_q <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH) begin
                hold_q <= fifo_rdata;
            end
        end
    end
`endif

    neighbor_bank_onehot_dec #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_dec (
        .bank_id (hold_q.bank_id),
        .valid   (issue_valid),
        .onehot  (bank_req_valid)
    );

    assign bank_req_data = issue_valid ? hold_q : '0;

    // Clear wins over a same-cycle acceptance; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dispatch_cnt <= '0;
        end else if (cnt_clear) begin
            dispatch_cnt <= '0;
        end else if (hs && (dispatch_cnt != CNT_MAX)) begin
            dispatch_cnt <= dispatch_cnt + 1'b1;
        end
    end

endmodule
